// File: rtl/video_pattern_gen.sv
// Video timing and test-pattern generator.
// A raster of H_TOTAL x V_TOTAL pixel clocks is scanned while the generator runs.
// Each pixel's control and colour values are registered one clock after the
// counter position they describe. Stopping is graceful: the frame in progress
// always finishes before the outputs go idle.
module video_pattern_gen #(
  parameter int H_ACTIVE  = 1280,
  parameter int H_FP      = 110,
  parameter int H_SYNC    = 40,
  parameter int H_BP      = 220,
  parameter int V_ACTIVE  = 720,
  parameter int V_FP      = 5,
  parameter int V_SYNC    = 5,
  parameter int V_BP      = 20,
  parameter bit HS_POL    = 1'b1,
  parameter bit VS_POL    = 1'b1,
  parameter int BAR_SHIFT = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] pattern_sel,
  input  logic [7:0] noise_thr,
  output logic       tx_dv,
  output logic       tx_hs,
  output logic       tx_vs,
  output logic [7:0] tx_red,
  output logic [7:0] tx_green,
  output logic [7:0] tx_blue,
  output logic       frame_start,
  output logic [1:0] dbg_state
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Counters are wide enough for the raster and for every bit the patterns
  // read (ramp needs h[7:0], bars need h[BAR_SHIFT+2], checker needs v[4]).
  localparam int HW_A = $clog2(H_TOTAL);
  localparam int HW_B = (HW_A > 8) ? HW_A : 8;
  localparam int HW   = (HW_B > BAR_SHIFT + 3) ? HW_B : BAR_SHIFT + 3;
  localparam int VW_A = $clog2(V_TOTAL);
  localparam int VW   = (VW_A > 5) ? VW_A : 5;

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEGIN = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEGIN = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_RUN       = 2'd1;
  localparam logic [1:0] S_STOP_PEND = 2'd2;

  logic [1:0]    state, state_nxt;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic [1:0]    sel_q;
  logic [7:0]    thr_q;
  logic [15:0]   lfsr_q;

  logic          counting, h_last, frame_first, frame_last, active, in_hs, in_vs;
  logic [1:0]    sel_eff;
  logic [7:0]    thr_eff;
  logic [15:0]   lfsr_cur, lfsr_nxt;
  logic [2:0]    bar;
  logic [7:0]    px_r, px_g, px_b;

  assign dbg_state   = state;
  assign counting    = (state != S_IDLE);
  assign h_last      = (h_cnt == H_LAST);
  assign frame_first = (h_cnt == '0) && (v_cnt == '0);
  assign frame_last  = h_last && (v_cnt == V_LAST);
  assign active      = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign in_hs       = (h_cnt >= HS_BEGIN) && (h_cnt < HS_END);
  assign in_vs       = (v_cnt >= VS_BEGIN) && (v_cnt < VS_END);

  // The first pixel of a frame already uses the newly sampled selection and
  // a freshly seeded LFSR, so every frame is self-contained and repeatable.
  assign sel_eff  = frame_first ? pattern_sel : sel_q;
  assign thr_eff  = frame_first ? noise_thr : thr_q;
  assign lfsr_cur = frame_first ? LFSR_SEED : lfsr_q;
  assign lfsr_nxt = {lfsr_cur[14:0], lfsr_cur[15] ^ lfsr_cur[13] ^ lfsr_cur[12] ^ lfsr_cur[10]};
  assign bar      = h_cnt[BAR_SHIFT+2:BAR_SHIFT];

  // Next-state logic: en only decides whether the frame after this one starts.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (en) state_nxt = S_RUN;
      S_RUN:       if (!en) state_nxt = frame_last ? S_IDLE : S_STOP_PEND;
      S_STOP_PEND: if (en) state_nxt = S_RUN;
                   else if (frame_last) state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // Pixel colour for the current counter position.
  always_comb begin
    px_r = 8'h00;
    px_g = 8'h00;
    px_b = 8'h00;
    case (sel_eff)
      2'd0: begin
        // white, yellow, cyan, green, magenta, red, blue, black
        px_r = {8{~bar[1]}};
        px_g = {8{~bar[2]}};
        px_b = {8{~bar[0]}};
      end
      2'd1: begin
        px_r = h_cnt[7:0];
        px_g = h_cnt[7:0];
        px_b = h_cnt[7:0];
      end
      2'd2: begin
        px_r = {8{h_cnt[4] ^ v_cnt[4]}};
        px_g = px_r;
        px_b = px_r;
      end
      default: begin
        if (lfsr_cur[7:0] < thr_eff) px_r = {8{lfsr_cur[8]}};
        else                         px_r = h_cnt[7:0];
        px_g = px_r;
        px_b = px_r;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Raster counters; held at the origin while idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst || !counting) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  // Per-frame selection latch and noise LFSR (advances on active pixels only).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel_q  <= 2'd0;
      thr_q  <= 8'd0;
      lfsr_q <= LFSR_SEED;
    end else if (counting) begin
      if (frame_first) begin
        sel_q <= pattern_sel;
        thr_q <= noise_thr;
      end
      if (active) lfsr_q <= lfsr_nxt;
      else        lfsr_q <= lfsr_cur;
    end
  end

  // Registered video outputs, one clock behind the counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst || !counting) begin
      tx_dv       <= 1'b0;
      tx_hs       <= ~HS_POL;
      tx_vs       <= ~VS_POL;
      tx_red      <= 8'h00;
      tx_green    <= 8'h00;
      tx_blue     <= 8'h00;
      frame_start <= 1'b0;
    end else begin
      tx_dv       <= active;
      tx_hs       <= in_hs ? HS_POL : ~HS_POL;
      tx_vs       <= in_vs ? VS_POL : ~VS_POL;
      tx_red      <= active ? px_r : 8'h00;
      tx_green    <= active ? px_g : 8'h00;
      tx_blue     <= active ? px_b : 8'h00;
      frame_start <= frame_first;
    end
  end

endmodule

// File: tb/tb_video_pattern_gen.sv
// Bench for video_pattern_gen on a small 24x12 raster.
// The reference model walks the raster position frame by frame, samples the
// pattern selection at each frame start and looks noise values up in a
// precomputed per-frame LFSR table.
module tb_video_pattern_gen;

  localparam int HA = 16, HF = 2, HSY = 2, HB = 4;
  localparam int VA = 8,  VF = 1, VSY = 1, VB = 2;
  localparam int BS = 1;
  localparam int HT = HA + HF + HSY + HB;  // 24
  localparam int VT = VA + VF + VSY + VB;  // 12

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       en = 1'b0;
  logic [1:0] pattern_sel = 2'd0;
  logic [7:0] noise_thr = 8'd0;

  logic       dv1, hs1, vs1, fs1;
  logic [7:0] r1, g1, b1;
  logic [1:0] st1;
  logic       dv2, hs2, vs2, fs2;
  logic [7:0] r2, g2, b2;
  logic [1:0] st2;

  video_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
    .HS_POL(1'b1), .VS_POL(1'b1), .BAR_SHIFT(BS)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .pattern_sel(pattern_sel), .noise_thr(noise_thr),
    .tx_dv(dv1), .tx_hs(hs1), .tx_vs(vs1), .tx_red(r1), .tx_green(g1), .tx_blue(b1),
    .frame_start(fs1), .dbg_state(st1)
  );

  video_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
    .HS_POL(1'b0), .VS_POL(1'b0), .BAR_SHIFT(BS)
  ) dut_neg (
    .clk(clk), .rst(rst), .en(en), .pattern_sel(pattern_sel), .noise_thr(noise_thr),
    .tx_dv(dv2), .tx_hs(hs2), .tx_vs(vs2), .tx_red(r2), .tx_green(g2), .tx_blue(b2),
    .frame_start(fs2), .dbg_state(st2)
  );

  int checks = 0;
  int errors = 0;

  // reference model state
  bit         m_active = 1'b0;
  int         m_h = 0, m_v = 0;
  int         m_sel = 0, m_thr = 0;
  int         e_pos = -1;
  logic [27:0] e_out, e_out2;
  logic [15:0] lfsr_tab [HA*VA];
  logic [23:0] bar_color [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  // scoreboard: expected outputs of the current cycle
  logic [27:0] exp_q [$];

  // frame capture for the repeatability check
  bit          cap_on = 1'b0;
  int          cap_idx = 0;
  logic [23:0] cap [2][HT*VT];

  function automatic logic [23:0] pixel(int sel, int thr, int h, int v);
    logic [7:0]  c;
    logic [15:0] l;
    case (sel)
      0: return bar_color[(h >> BS) % 8];
      1: c = 8'(h);
      2: c = ((((h >> 4) ^ (v >> 4)) & 1) != 0) ? 8'hFF : 8'h00;
      default: begin
        l = lfsr_tab[v*HA + h];
        if (int'(l[7:0]) < thr) c = l[8] ? 8'hFF : 8'h00;
        else                    c = 8'(h);
      end
    endcase
    return {c, c, c};
  endfunction

  function automatic logic [27:0] expect_px(int h, int v, int sel, int thr);
    bit dv, hs, vs, fs;
    dv = (h < HA) && (v < VA);
    hs = (h >= HA + HF) && (h < HA + HF + HSY);
    vs = (v >= VA + VF) && (v < VA + VF + VSY);
    fs = (h == 0) && (v == 0);
    return {fs, dv, hs, vs, dv ? pixel(sel, thr, h, v) : 24'h000000};
  endfunction

  task automatic check(string tag, logic [27:0] observed, logic [27:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s pos=(%0d,%0d) observed=%h expected=%h", tag, m_h, m_v, observed, expected);
    end
  endtask

  // One clock: predict what the edge registers, then compare at the falling edge.
  task automatic tick();
    logic [27:0] o1;
    @(posedge clk);
    e_pos = -1;
    if (!rst) begin
      exp_q.push_back(28'h0);
      m_active = 1'b0; m_h = 0; m_v = 0;
    end else if (m_active) begin
      if (m_h == 0 && m_v == 0) begin
        m_sel = int'(pattern_sel);
        m_thr = int'(noise_thr);
      end
      exp_q.push_back(expect_px(m_h, m_v, m_sel, m_thr));
      e_pos = m_v*HT + m_h;
      if (m_h == HT-1 && m_v == VT-1) begin
        m_active = en; m_h = 0; m_v = 0;
      end else if (m_h == HT-1) begin
        m_h = 0; m_v++;
      end else begin
        m_h++;
      end
    end else begin
      exp_q.push_back(28'h0);
      if (en) begin
        m_active = 1'b1; m_h = 0; m_v = 0;
      end
    end
    @(negedge clk);
    e_out  = exp_q.pop_front();
    e_out2 = {e_out[27:26], ~e_out[25:24], e_out[23:0]};
    o1 = {fs1, dv1, hs1, vs1, r1, g1, b1};
    check("pos_pol", o1, e_out);
    check("neg_pol", {fs2, dv2, hs2, vs2, r2, g2, b2}, e_out2);
    if (cap_on && e_pos >= 0) cap[cap_idx][e_pos] = o1[23:0];
  endtask

  // Tick until the model's next pixel is (h,v) in a running frame.
  task automatic wait_pos(int h, int v);
    int n = 0;
    while (!(m_active && m_h == h && m_v == v) && n < 2*HT*VT) begin
      tick();
      n++;
    end
    if (!(m_active && m_h == h && m_v == v)) begin
      errors++;
      $display("FAIL wait_pos(%0d,%0d) observed=timeout expected=reached", h, v);
    end
  endtask

  // Start a frame with the given selection, then scramble the inputs mid-frame.
  task automatic run_frame(int sel, int thr);
    pattern_sel = 2'(sel);
    noise_thr   = 8'(thr);
    tick();
    repeat ($urandom_range(1, 250)) tick();
    pattern_sel = 2'($urandom);
    noise_thr   = 8'($urandom);
    wait_pos(0, 0);
  endtask

  initial begin
    logic [15:0] s;
    int diff;
    s = 16'hACE1;
    for (int k = 0; k < HA*VA; k++) begin
      lfsr_tab[k] = s;
      s = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    end

    // asynchronous reset with no clock edge
    #1 rst = 1'b0;
    #1;
    check("reset_pos", {fs1, dv1, hs1, vs1, r1, g1, b1}, 28'h0);
    check("reset_neg", {fs2, dv2, hs2, vs2, r2, g2, b2}, 28'h300_0000);
    repeat (3) tick();
    rst = 1'b1;
    repeat (4) tick();

    // start, then each pattern with mid-frame input changes
    en = 1'b1;
    wait_pos(0, 0);
    run_frame(0, 0);
    run_frame(1, 0);
    run_frame(2, 0);
    run_frame(3, 0);

    // two noisy frames must repeat exactly
    cap_on = 1'b1; cap_idx = 0;
    run_frame(3, 128);
    cap_idx = 1;
    run_frame(3, 128);
    cap_on = 1'b0;
    diff = 0;
    for (int p = 0; p < HT*VA; p++) if (cap[0][p] !== cap[1][p]) diff++;
    check("frame_repeat", 28'(diff), 28'd0);
    run_frame(3, int'($urandom_range(0, 255)));

    // en dropped at line 3: frame completes, then idle
    wait_pos(0, 3);
    en = 1'b0;
    repeat (HT*(VT-3) + 10) tick();

    // restart, drop en at line 2, re-raise at line 6: seamless continuation
    en = 1'b1;
    wait_pos(0, 0);
    pattern_sel = 2'd1;
    wait_pos(0, 2);
    en = 1'b0;
    wait_pos(5, 6);
    en = 1'b1;
    wait_pos(0, 0);
    run_frame(0, 0);

    // en low only during the last cycle of a frame
    wait_pos(HT-1, VT-1);
    en = 1'b0;
    tick();
    en = 1'b1;
    repeat (3) tick();

    // asynchronous reset mid-frame at line 5
    wait_pos(3, 5);
    #2 rst = 1'b0;
    #1;
    check("rst_mid_pos", {fs1, dv1, hs1, vs1, r1, g1, b1}, 28'h0);
    check("rst_mid_neg", {fs2, dv2, hs2, vs2, r2, g2, b2}, 28'h300_0000);
    m_active = 1'b0; m_h = 0; m_v = 0;
    repeat (2) tick();
    rst = 1'b1;
    wait_pos(0, 0);
    run_frame(0, 0);

    // randomized run/stop and selection traffic
    repeat (1500) begin
      if ($urandom_range(0, 99) < 2) en = ~en;
      pattern_sel = 2'($urandom);
      noise_thr   = 8'($urandom);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
